// File: rtl/shift_sub_divider_if.sv
// rtl/shift_sub_divider_if.sv - request/result bundle for the shift-subtract divider
interface shift_sub_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - restoring divider, one quotient bit per clock
// Define DIV_SIGNED_EN for two's-complement (truncating) division.
module shift_sub_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  shift_sub_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;
  logic             dz;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  assign t    = {r[WIDTH-1:0], q[WIDTH-1]};
  assign diff = t - {1'b0, d};
  assign ge   = (t >= {1'b0, d});

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + ONE) : bus.dividend;
  assign b_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + ONE)  : bus.divisor;
  assign res_q = neg_q ? (~q + ONE) : q;
  assign res_r = neg_r ? (~r[WIDTH-1:0] + ONE) : r[WIDTH-1:0];
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign res_q = q;
  assign res_r = r[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      r               <= '0;
      q               <= '0;
      d               <= '0;
      count           <= '0;
      dz              <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              r        <= '0;
              q        <= a_mag;
              d        <= b_mag;
              count    <= '0;
              dz       <= 1'b0;
              bus.busy <= 1'b1;
              state    <= CALC;
`ifdef DIV_SIGNED_EN
              neg_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              neg_r    <= bus.dividend[WIDTH-1];
`endif
            end else begin
              // Raw dividend passes straight through as the remainder.
              q     <= '1;
              r     <= {1'b0, bus.dividend};
              dz    <= 1'b1;
              state <= FIN;
`ifdef DIV_SIGNED_EN
              neg_q <= 1'b0;
              neg_r <= 1'b0;
`endif
            end
          end
        end
        CALC: begin
          r     <= ge ? diff : t;
          q     <= {q[WIDTH-2:0], ge};
          count <= count + 1'b1;
          if (count == LAST) begin
            bus.busy <= 1'b0;
            state    <= FIN;
          end
        end
        FIN: begin
          bus.quotient    <= res_q;
          bus.remainder   <= res_r;
          bus.div_by_zero <= dz;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          dz              <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb/tb_shift_sub_divider.sv - randomized self-checking bench for shift_sub_divider
module tb_shift_sub_divider;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   since;
  int   busy_cnt;

  shift_sub_divider_if #(.WIDTH(8)) bus ();

  shift_sub_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dz);
    int sa;
    int sb;
    sa = 0;
    sb = 0;
    if (b == 8'd0) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      dz = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since++;
    if (bus.busy) busy_cnt++;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    since    = 0;
    busy_cnt = bus.busy ? 1 : 0;
  endtask

  task automatic wait_done(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq;
    logic [7:0] er;
    logic       edz;
    model(a, b, eq, er, edz);
    while (!bus.done && since < 40) tick();
    check({tag, ".lat"},  since, (b == 8'd0) ? 1 : 9);
    check({tag, ".busy"}, busy_cnt, (b == 8'd0) ? 0 : 8);
    check({tag, ".q"},    bus.quotient, eq);
    check({tag, ".r"},    bus.remainder, er);
    check({tag, ".dz"},   bus.div_by_zero, edz);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    issue(a, b);
    wait_done(tag, a, b);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    total = 0;
    bad   = 0;
    since = 0;
    busy_cnt = 0;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    reset = 1'b1;
    #2;
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.q",    bus.quotient, 0);
    check("rst.r",    bus.remainder, 0);
    check("rst.dz",   bus.div_by_zero, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    run_op("d100_7", 8'd100, 8'd7);
    tick();
    check("done_pulse", bus.done, 0);
    check("hold_q", bus.quotient, 8'd14);
    run_op("d255_1", 8'd255, 8'd1);
    run_op("d0_5",   8'd0,   8'd5);
    run_op("d6_200", 8'd6,   8'd200);
    run_op("d13_0",  8'd13,  8'd0);
    run_op("d20_4",  8'd20,  8'd4);

    issue(8'd100, 8'd7);
    tick();
    tick();
    bus.start    = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor  = 8'd3;
    tick();
    bus.start    = 1'b0;
    check("hold_mid", bus.quotient, 8'd5);
    wait_done("ignore", 8'd100, 8'd7);
    issue(8'd9, 8'd2);
    wait_done("b2b", 8'd9, 8'd2);

    issue(8'd200, 8'd3);
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst.busy", bus.busy, 0);
    check("arst.done", bus.done, 0);
    check("arst.q",    bus.quotient, 0);
    check("arst.r",    bus.remainder, 0);
    check("arst.dz",   bus.div_by_zero, 0);
    #2;
    reset = 1'b0;
    tick();
    run_op("d50_3", 8'd50, 8'd3);

`ifdef DIV_SIGNED_EN
    run_op("sn100_7",  8'h9C, 8'd7);
    run_op("s100_n7",  8'd100, 8'hF9);
    run_op("sn128_n1", 8'h80, 8'hFF);
    run_op("sn128_1",  8'h80, 8'h01);
`endif

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      run_op($sformatf("rnd%0d", i), a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
